// File: rtl/custom_op_mem_if.sv
// custom_op_mem_if: data-memory request/grant port between the custom-op engine and memory.
// One read may be outstanding; rvalid/rdata return its data.
interface custom_op_mem_if #(
    parameter int XLEN   = 19,
    parameter int ADDR_W = 19
) ();
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic              gnt;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;
    modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/custom_op_seq.sv
// custom_op_seq: multi-cycle read-modify-write sequencer for FFT/ENCRYPT/DECRYPT custom ops.
// Streams BLOCK_WORDS words through the memory port while holding busy_o.
module custom_op_seq #(
    parameter int XLEN        = 19,
    parameter int ADDR_W      = 19,
    parameter int BLOCK_WORDS = 8,
    parameter int ROT         = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start_i,
    input  logic [1:0]                         op_i,
    input  logic [ADDR_W-1:0]                  base_addr_i,
    input  logic [XLEN-1:0]                    key_i,
    input  logic                               flush_i,
    custom_op_mem_if.master                    mem,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic [$clog2(BLOCK_WORDS+1)-1:0]   words_o
);
    localparam int CW = $clog2(BLOCK_WORDS + 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_RD_A = 3'd1, S_RD_B = 3'd2,
                           S_WR_A = 3'd3, S_WR_B = 3'd4, S_DONE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d, words_q, words_d, idx_nx;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [XLEN-1:0]   key_q, key_d, a_q, a_d, b_q, b_d, x, enc, dec;
    logic              pend_q, pend_d, err_q, err_d;
    logic              fft, is_rd, is_wr, second, rd_take;

    assign fft     = op_q == 2'b01;
    assign is_rd   = state_q == S_RD_A || state_q == S_RD_B;
    assign is_wr   = state_q == S_WR_A || state_q == S_WR_B;
    assign second  = state_q == S_RD_B || state_q == S_WR_B;
    assign x       = a_q ^ key_q;
    assign enc     = (x << ROT) | (x >> (XLEN - ROT));
    assign dec     = ((a_q >> ROT) | (a_q << (XLEN - ROT))) ^ key_q;
    // pend_q marks a granted read still waiting for its data; req stays low meanwhile
    assign rd_take = is_rd && mem.rvalid && (pend_q || mem.gnt);
    assign idx_nx  = idx_q + (state_q == S_WR_B ? CW'(2) : CW'(1));

    assign mem.req   = (is_rd && !pend_q) || is_wr;
    assign mem.wr    = is_wr;
    assign mem.addr  = base_q + ADDR_W'(idx_q) + ADDR_W'(second);
    assign mem.wdata = state_q == S_WR_B ? a_q - b_q :
                       fft ? a_q + b_q : op_q == 2'b10 ? enc : dec;

    assign busy_o  = state_q != S_IDLE;
    assign done_o  = state_q == S_DONE;
    assign err_o   = err_q;
    assign words_o = words_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        op_d    = op_q;
        base_d  = base_q;
        key_d   = key_q;
        a_d     = a_q;
        b_d     = b_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (start_i && !flush_i) begin
                if (op_i == 2'b00) err_d = 1'b1;
                else begin
                    state_d = S_RD_A;
                    op_d    = op_i;
                    base_d  = base_addr_i;
                    key_d   = key_i;
                    idx_d   = '0;
                    words_d = '0;
                end
            end
            S_RD_A, S_RD_B: begin
                if (mem.gnt && !pend_q && !mem.rvalid) pend_d = 1'b1;
                if (rd_take) begin
                    pend_d = 1'b0;
                    if (state_q == S_RD_A) begin
                        a_d     = mem.rdata;
                        state_d = fft ? S_RD_B : S_WR_A;
                    end else begin
                        b_d     = mem.rdata;
                        state_d = S_WR_A;
                    end
                end
            end
            S_WR_A, S_WR_B: if (mem.gnt) begin
                words_d = words_q + CW'(1);
                if (state_q == S_WR_A && fft) state_d = S_WR_B;
                else begin
                    idx_d   = idx_nx;
                    state_d = idx_nx == CW'(BLOCK_WORDS) ? S_DONE : S_RD_A;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            words_q <= '0;
            op_q    <= '0;
            base_q  <= '0;
            key_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            op_q    <= op_d;
            base_q  <= base_d;
            key_q   <= key_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_custom_op_seq.sv
// tb_custom_op_seq: directed tests for custom_op_seq against a transaction-level model
// of the expected memory traffic, with a memory slave that can stall grants and delay data.
module tb_custom_op_seq;
    typedef struct {
        logic        wr;
        logic [18:0] addr;
        logic [18:0] data;
    } txn_t;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [18:0] base = '0, key = '0;
    logic        busy_o, done_o, err_o;
    logic [3:0]  words_o;
    logic [18:0] mem [0:524287];
    txn_t        exp_q [$];
    int          vecs = 0, errs = 0, grants = 0, done_cnt = 0;
    int          gnt_wait = 0, rd_lat = 1, rd_cnt = 0, wcnt = 0;
    bit          spur = 1'b0, hold = 1'b0, flush_edge = 1'b0;
    logic [18:0] rd_data;
    logic [57:0] prev_req;

    custom_op_mem_if #(.XLEN(19), .ADDR_W(19)) mif ();

    custom_op_seq dut (
        .clk(clk), .reset_n(reset_n), .start_i(start), .op_i(op), .base_addr_i(base),
        .key_i(key), .flush_i(flush), .mem(mif), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .words_o(words_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [18:0] wa(input logic [18:0] b, input int i);
        return 19'((int'(b) + i) % 524288);
    endfunction

    function automatic logic [18:0] m_enc(input logic [18:0] w, input logic [18:0] k);
        int y;
        y = int'(w ^ k);
        return 19'(((y * 8) % 524288) + y / 65536);
    endfunction

    function automatic logic [18:0] m_dec(input logic [18:0] w, input logic [18:0] k);
        int y;
        y = int'(w);
        return 19'(y / 8 + (y % 8) * 65536) ^ k;
    endfunction

    // expected request stream for one whole operation, from the current memory image
    task automatic plan(input logic [1:0] o, input logic [18:0] b, input logic [18:0] k);
        logic [18:0] a, bb;
        for (int i = 0; i < 8; i += (o == 2'b01) ? 2 : 1) begin
            a = mem[wa(b, i)];
            if (o == 2'b01) begin
                bb = mem[wa(b, i + 1)];
                exp_q.push_back('{1'b0, wa(b, i), 19'd0});
                exp_q.push_back('{1'b0, wa(b, i + 1), 19'd0});
                exp_q.push_back('{1'b1, wa(b, i), 19'((int'(a) + int'(bb)) % 524288)});
                exp_q.push_back('{1'b1, wa(b, i + 1), 19'((int'(a) - int'(bb) + 524288) % 524288)});
            end else begin
                exp_q.push_back('{1'b0, wa(b, i), 19'd0});
                exp_q.push_back('{1'b1, wa(b, i), o == 2'b10 ? m_enc(a, k) : m_dec(a, k)});
            end
        end
    endtask

    always @(posedge clk) flush_edge = flush;

    // memory slave + per-grant transaction compare
    always @(negedge clk) begin
        txn_t t;
        mif.gnt = 1'b0;
        mif.rvalid = 1'b0;
        if (!reset_n) begin
            rd_cnt = 0;
            hold = 1'b0;
            wcnt = 0;
        end else begin
            if (hold && !flush_edge)
                chk("req_stable", {6'd0, mif.req, mif.wr, mif.addr, mif.wdata}, {6'd0, prev_req});
            hold = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mif.rvalid = 1'b1;
                    mif.rdata = rd_data;
                end
            end
            if (mif.req) begin
                if (wcnt < gnt_wait) begin
                    wcnt++;
                    hold = 1'b1;
                    prev_req = {mif.req, mif.wr, mif.addr, mif.wdata};
                end else begin
                    wcnt = 0;
                    mif.gnt = 1'b1;
                    grants++;
                    if (exp_q.size() == 0) chk("txn_unexpected", 1, 0);
                    else begin
                        t = exp_q.pop_front();
                        chk("txn_wr", 32'(mif.wr), 32'(t.wr));
                        chk("txn_addr", 32'(mif.addr), 32'(t.addr));
                        if (t.wr) chk("txn_wdata", 32'(mif.wdata), 32'(t.data));
                    end
                    if (mif.wr) mem[mif.addr] = mif.wdata;
                    else if (rd_lat == 0) begin
                        mif.rvalid = 1'b1;
                        mif.rdata = mem[mif.addr];
                    end else begin
                        rd_cnt = rd_lat;
                        rd_data = mem[mif.addr];
                    end
                end
            end else wcnt = 0;
            if (spur && !mif.rvalid && rd_cnt == 0 && !(mif.gnt && !mif.wr)) begin
                mif.rvalid = 1'b1;
                mif.rdata = 19'($urandom);
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic launch(input logic [1:0] o, input logic [18:0] b, input logic [18:0] k);
        if (o != 2'b00) plan(o, b, k);
        grants = 0;
        @(negedge clk);
        start = 1'b1;
        op = o;
        base = b;
        key = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [1:0] o, input logic [18:0] b, input logic [18:0] k);
        bit seen;
        launch(o, b, k);
        chk("busy_after_launch", 32'(busy_o), 1);
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (done_o) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", 32'(seen), 1);
        if (seen) begin
            chk("busy_at_done", 32'(busy_o), 1);
            chk("words_at_done", 32'(words_o), 8);
            chk("grants", 32'(grants), 16);
            chk("queue_drained", 32'(exp_q.size()), 0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done_o), 0);
            chk("idle_after_done", 32'(busy_o), 0);
            chk("words_hold", 32'(words_o), 8);
        end
        exp_q.delete();
    endtask

    initial begin
        int d0;
        logic [18:0] r [0:7];
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [18:0] r [0:7];
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_words", 32'(words_o), 0);
        chk("rst_req", 32'(mif.req), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // ENCRYPT, key 1, base 0x10
        for (int i = 0; i < 8; i++) mem[16 + i] = 19'(i + 1);
        run(2'b10, 19'h10, 19'h1);
        chk("enc_w0", 32'(mem[19'h10]), 32'h0);
        chk("enc_w1", 32'(mem[19'h11]), 32'h18);
        chk("enc_w7", 32'(mem[19'h17]), 32'h48);

        // DECRYPT restores the original block
        rd_lat = 3;
        run(2'b11, 19'h10, 19'h1);
        for (int i = 0; i < 8; i++) chk("dec_restore", 32'(mem[16 + i]), 32'(i + 1));

        // FFT butterflies
        rd_lat = 1;
        mem[19'h20] = 19'd5;       mem[19'h21] = 19'd7;
        mem[19'h22] = 19'd1;       mem[19'h23] = 19'd2;
        mem[19'h24] = 19'h7FFFF;   mem[19'h25] = 19'd1;
        mem[19'h26] = 19'h40000;   mem[19'h27] = 19'h40000;
        run(2'b01, 19'h20, 19'h0);
        chk("fft_a0", 32'(mem[19'h20]), 32'hC);
        chk("fft_b0", 32'(mem[19'h21]), 32'h7FFFE);
        chk("fft_a2", 32'(mem[19'h24]), 32'h0);
        chk("fft_b2", 32'(mem[19'h25]), 32'h7FFFE);
        chk("fft_a3", 32'(mem[19'h26]), 32'h0);

        // grant stalled 5 cycles per request
        gnt_wait = 5;
        for (int i = 0; i < 8; i++) mem[48 + i] = 19'(i + 1);
        run(2'b10, 19'h30, 19'h1);
        chk("stall_w1", 32'(mem[19'h31]), 32'h18);
        chk("stall_w7", 32'(mem[19'h37]), 32'h48);

        // address wrap, same-cycle rvalid, stray rvalid pulses
        gnt_wait = 1;
        rd_lat = 0;
        spur = 1'b1;
        mem[19'h7FFFD] = 19'h12345;
        mem[19'h00006] = 19'h54321;
        for (int i = 0; i < 8; i++) begin
            r[i] = 19'($urandom);
            mem[wa(19'h7FFFE, i)] = r[i];
        end
        run(2'b11, 19'h7FFFE, 19'h5A5A5);
        chk("wrap_first", 32'(mem[19'h7FFFE]), 32'(m_dec(r[0], 19'h5A5A5)));
        chk("wrap_zero", 32'(mem[19'h00000]), 32'(m_dec(r[2], 19'h5A5A5)));
        chk("wrap_below", 32'(mem[19'h7FFFD]), 32'h12345);
        chk("wrap_after", 32'(mem[19'h00006]), 32'h54321);
        spur = 1'b0;
        gnt_wait = 0;
        rd_lat = 1;

        // illegal op
        @(negedge clk);
        start = 1'b1;
        op = 2'b00;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err_o), 1);
        chk("err_not_busy", 32'(busy_o), 0);
        @(negedge clk);
        chk("err_one_cycle", 32'(err_o), 0);
        chk("err_still_idle", 32'(busy_o), 0);

        // flush in WR_A of word 3
        gnt_wait = 5;
        d0 = done_cnt;
        launch(2'b10, 19'h40, 19'h3);
        for (int c = 0; c < 500 && !(mif.req && mif.wr && mif.addr == 19'h43); c++) @(negedge clk);
        chk("flush_reached_w3", 32'(mif.req && mif.wr && mif.addr == 19'h43), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", 32'(busy_o), 0);
        chk("flush_req", 32'(mif.req), 0);
        chk("flush_words", 32'(words_o), 3);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("flush_no_done", 32'(done_cnt - d0), 0);
        chk("flush_words_hold", 32'(words_o), 3);
        gnt_wait = 0;

        // flush and start together in IDLE
        start = 1'b1;
        flush = 1'b1;
        op = 2'b10;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_beats_start", 32'(busy_o), 0);
        chk("flush_start_no_err", 32'(err_o), 0);

        // asynchronous reset mid-operation
        d0 = done_cnt;
        launch(2'b01, 19'h50, 19'h0);
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", 32'(busy_o), 1);
        reset_n = 1'b0;
        #1;
        chk("areset_busy", 32'(busy_o), 0);
        chk("areset_req", 32'(mif.req), 0);
        chk("areset_done", 32'(done_o), 0);
        chk("areset_words", 32'(words_o), 0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("areset_no_done", 32'(done_cnt - d0), 0);
        chk("areset_idle", 32'(busy_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
